// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fb_pkg
//  Description : Shared framebuffer video timing defaults, derived frame
//                totals, control-bundle type and the scroll-address helper.
//                Also used by the framebuffer writer.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

  // Pixel width of the framebuffer
  localparam int PIX_W_DEF  = 8;

  // Horizontal timing, in clocks
  localparam int H_ACT_DEF  = 160;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 32;
  localparam int H_BP_DEF   = 48;

  // Vertical timing, in lines
  localparam int V_ACT_DEF  = 144;
  localparam int V_FP_DEF   = 3;
  localparam int V_SYNC_DEF = 4;
  localparam int V_BP_DEF   = 12;

  // Derived totals
  localparam int HT_DEF = H_ACT_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int VT_DEF = V_ACT_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Framebuffer is 256x256: 8 bits of row, 8 bits of column
  localparam int FB_AW = 16;

  // Per-pixel control bundle carried down the scanout pipeline
  typedef struct packed {
    logic act;    // inside the active window
    logic hs;     // horizontal sync
    logic vs;     // vertical sync
    logic first;  // first pixel of the frame (h=0, v=0)
  } vid_ctl_t;

  // One byte of the scrolled address: counter plus offset, wrapping at 256
  function automatic logic [7:0] scroll_byte(input logic [15:0] cnt,
                                             input logic [7:0]  off);
    logic [7:0] sum;
    sum = cnt[7:0] + off;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_scanout_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fb_scanout_if
//  Description : Framebuffer read port plus video output bundle of the
//                scanout engine. The master is the scanout engine; the slave
//                side is the framebuffer memory and display sink.
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_scanout_if
  import fb_pkg::*;
#(
  parameter int B = PIX_W_DEF
);
  logic [FB_AW-1:0] fb_addr;
  logic [B-1:0]     fb_data;
  logic [B-1:0]     pix;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             frame_start;

  modport master (
    output fb_addr,
    input  fb_data,
    output pix,
    output de,
    output hsync,
    output vsync,
    output frame_start
  );

  modport slave (
    input  fb_addr,
    output fb_data,
    input  pix,
    input  de,
    input  hsync,
    input  vsync,
    input  frame_start
  );
endinterface
`default_nettype wire

// File: rtl/fb_timing.sv
`default_nettype none
// ============================================================================
//  Module      : fb_timing
//  Description : Horizontal/vertical raster counters and the stage-0
//                active / hsync / vsync / first-pixel decode. Counters are
//                held at (0,0) while en is low so the frame restarts cleanly.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_timing
  import fb_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF,
  parameter int HW     = $clog2(H_ACT + H_FP + H_SYNC + H_BP),
  parameter int VW     = $clog2(V_ACT + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output vid_ctl_t      ctl
);

  localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  // Next raster position: advance while enabled, park at (0,0) otherwise
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (int'(h_q) == HT - 1) begin
      h_d = '0;
      v_d = (int'(v_q) == VT - 1) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  // Raster counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 decode of the current raster position
  always_comb begin
    ctl       = '0;
    ctl.act   = en && (int'(h_q) < H_ACT) && (int'(v_q) < V_ACT);
    ctl.hs    = en && (int'(h_q) >= H_ACT + H_FP)
                   && (int'(h_q) <  H_ACT + H_FP + H_SYNC);
    ctl.vs    = en && (int'(v_q) >= V_ACT + V_FP)
                   && (int'(v_q) <  V_ACT + V_FP + V_SYNC);
    ctl.first = en && (h_q == '0) && (v_q == '0);
  end

  assign h = h_q;
  assign v = v_q;

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout
//  Description : Scrolling framebuffer scanout. Generates the raster, issues a
//                registered 256x256 framebuffer read address offset by the
//                per-frame scroll, and delay-matches active/sync/first-pixel
//                so pix, de, hsync, vsync and frame_start line up three clocks
//                after the raster position that produced them.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_scanout
  import fb_pkg::*;
#(
  parameter int B      = PIX_W_DEF,
  parameter int H_ACT  = H_ACT_DEF,
  parameter int H_FP   = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP   = H_BP_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int V_FP   = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP   = V_BP_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [7:0]   scx,
  input  logic [7:0]   scy,
  fb_scanout_if.master bus
);

  localparam int HW = $clog2(H_ACT + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACT + V_FP + V_SYNC + V_BP);

  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  vid_ctl_t         ctl0;

  logic [7:0]       sx_q, sx_d, sy_q, sy_d;
  logic [7:0]       sx_eff, sy_eff;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;

  vid_ctl_t         s1_q, s1_d;   // aligned with fb_addr
  vid_ctl_t         s2_q, s2_d;   // aligned with fb_data
  vid_ctl_t         out_q, out_d; // aligned with pix
  logic [B-1:0]     pix_q, pix_d;

  fb_timing #(
    .H_ACT  (H_ACT),
    .H_FP   (H_FP),
    .H_SYNC (H_SYNC),
    .H_BP   (H_BP),
    .V_ACT  (V_ACT),
    .V_FP   (V_FP),
    .V_SYNC (V_SYNC),
    .V_BP   (V_BP),
    .HW     (HW),
    .VW     (VW)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .h     (h),
    .v     (v),
    .ctl   (ctl0)
  );

  // Scroll capture at the frame origin; the origin pixel already uses the new value
  always_comb begin
    sx_eff    = ctl0.first ? scx : sx_q;
    sy_eff    = ctl0.first ? scy : sy_q;
    sx_d      = sx_eff;
    sy_d      = sy_eff;
    fb_addr_d = {scroll_byte(16'(v), sy_eff), scroll_byte(16'(h), sx_eff)};
  end

  // Delay-match the control bundle to the memory read; en low flushes it
  always_comb begin
    s1_d  = en ? ctl0 : '0;
    s2_d  = en ? s1_q : '0;
    out_d = en ? s2_q : '0;
    pix_d = (en && s2_q.act) ? bus.fb_data : '0;
  end

  // Scroll, address and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q      <= '0;
      sy_q      <= '0;
      fb_addr_q <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_q     <= '0;
      pix_q     <= '0;
    end else begin
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      fb_addr_q <= fb_addr_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_q     <= out_d;
      pix_q     <= pix_d;
    end
  end

  assign bus.fb_addr     = fb_addr_q;
  assign bus.pix         = pix_q;
  assign bus.de          = out_q.act;
  assign bus.hsync       = out_q.hs;
  assign bus.vsync       = out_q.vs;
  assign bus.frame_start = out_q.first;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fb_scanout
//  Description : Testbench for fb_scanout. A raster-position reference model
//                pushes the expected outputs for every clock into a queue; a
//                monitor pops and compares them. Directed checks cover reset,
//                start-up latency, scroll addressing, timing and en/reset
//                restarts; a final phase randomizes en and scroll.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_scanout;

  localparam int B     = 8;
  localparam int HT    = 256;
  localparam int VT    = 163;
  localparam int FRAME = HT * VT;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [7:0] scx   = 8'd0;
  logic [7:0] scy   = 8'd0;

  int checks   = 0;
  int failures = 0;

  fb_scanout_if #(.B(B)) bus ();

  fb_scanout #(.B(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .scx   (scx),
    .scy   (scy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: low byte XOR high byte (row 0 reads back the column)
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  // Synchronous-read framebuffer model
  always @(posedge clk) bus.fb_data <= mem_val(bus.fb_addr);

  // ---------------------------------------------------------------- model
  typedef struct {
    bit en;
    int p;
    int sx;
    int sy;
  } ent_t;

  typedef struct {
    bit          addr_chk;
    logic [15:0] addr;
    logic [7:0]  pix;
    bit          de;
    bit          hs;
    bit          vs;
    bit          fs;
  } exp_t;

  ent_t hist [3];
  exp_t exp_q [$];
  int   mdl_p    = 0;
  int   frame_sx = 0;
  int   frame_sy = 0;

  function automatic logic [15:0] addr_of(input ent_t e);
    int hh, vv;
    hh = e.p % HT;
    vv = e.p / HT;
    return {8'((vv + e.sy) % 256), 8'((hh + e.sx) % 256)};
  endfunction

  // Each clock: record this cycle's raster position and predict next cycle's outputs
  always @(posedge clk) begin
    ent_t e;
    exp_t x;
    bit   en_eff, run;
    int   h0, v0;
    en_eff = rst_n && en;
    if (!rst_n) begin
      frame_sx = 0;
      frame_sy = 0;
    end
    if (en_eff && mdl_p == 0) begin
      frame_sx = int'(scx);
      frame_sy = int'(scy);
    end
    e.en = en_eff;
    e.p  = mdl_p;
    e.sx = frame_sx;
    e.sy = frame_sy;
    hist[0] = hist[1];
    hist[1] = hist[2];
    hist[2] = e;
    x.addr_chk = e.en;
    x.addr     = addr_of(e);
    run  = hist[0].en && hist[1].en && hist[2].en;
    h0   = hist[0].p % HT;
    v0   = hist[0].p / HT;
    x.de  = run && h0 < 160 && v0 < 144;
    x.pix = x.de ? mem_val(addr_of(hist[0])) : 8'd0;
    x.hs  = run && h0 >= 176 && h0 < 208;
    x.vs  = run && v0 >= 147 && v0 < 151;
    x.fs  = x.de && hist[0].p == 0;
    exp_q.push_back(x);
    mdl_p = en_eff ? (mdl_p + 1) % FRAME : 0;
  end

  // Monitor: compare every clock's outputs against the predicted entry
  always @(negedge clk) begin
    exp_t        x;
    logic [11:0] got, want;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      if (!rst_n) begin
        x.addr_chk = 1'b1;
        x.addr     = 16'h0000;
        x.pix      = 8'd0;
        x.de       = 1'b0;
        x.hs       = 1'b0;
        x.vs       = 1'b0;
        x.fs       = 1'b0;
      end
      got  = {bus.pix, bus.de, bus.hsync, bus.vsync, bus.frame_start};
      want = {x.pix, x.de, x.hs, x.vs, x.fs};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sb_video t=%0t actual pix/de/hs/vs/fs=0x%03h required=0x%03h",
                 $time, got, want);
      end
      if (x.addr_chk) begin
        checks++;
        if (bus.fb_addr !== x.addr) begin
          failures++;
          $display("FAIL sb_addr t=%0t actual=0x%04h required=0x%04h",
                   $time, bus.fb_addr, x.addr);
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_pos(input int target);
    int n;
    n = 0;
    while (mdl_p != target && n < FRAME + 10) begin
      step();
      n++;
    end
    if (mdl_p != target) begin
      checks++;
      failures++;
      $display("FAIL wait_pos actual=%0d required=%0d", mdl_p, target);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {19'd0, bus.pix, bus.de, bus.hsync, bus.vsync, bus.frame_start};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    int   de_run, lines, bad_runs, de_fall_i, hs_run, hs_len_bad, hs_count;
    int   hs_gap_bad, hs_gaps, vs_total, vs_first, vs_last, fs_prev, period;
    logic prev_de, prev_hs;

    // Reset state
    repeat (3) step();
    check("reset_outputs", outs_vec(), 32'd0);
    check("reset_fb_addr", 32'(bus.fb_addr), 32'd0);

    // Release with en=1: this cycle is raster (0,0)
    rst_n = 1'b1;
    en    = 1'b1;

    de_run = 0; lines = 0; bad_runs = 0; de_fall_i = -1000;
    hs_run = 0; hs_len_bad = 0; hs_count = 0; hs_gap_bad = 0; hs_gaps = 0;
    vs_total = 0; vs_first = -1; vs_last = -1; fs_prev = -1; period = -1;
    prev_de = 1'b0; prev_hs = 1'b0;

    // Frame A: latency, first line content and full-frame timing
    for (int i = 1; i <= FRAME + 3; i++) begin
      if (i == 30 * HT) begin
        scx = 8'($urandom);
        scy = 8'($urandom);
      end
      if (i == 100 * HT) begin
        scx = 8'd250;
        scy = 8'd200;
      end
      step();
      if (i == 2) check("start_de_early", 32'(bus.de), 32'd0);
      if (i == 3) check("start_de_fs_pix", outs_vec(), {19'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      if (i >= 3 && i < 3 + 160) check("line0_pix", 32'(bus.pix), 32'(i - 3));

      if (bus.de) de_run++;
      if (prev_de && !bus.de) begin
        lines++;
        if (de_run != 160) bad_runs++;
        de_run    = 0;
        de_fall_i = i;
      end
      if (bus.hsync) hs_run++;
      if (bus.hsync && !prev_hs) begin
        hs_count++;
        if (i - de_fall_i < HT) begin
          hs_gaps++;
          if (i - de_fall_i != 16) hs_gap_bad++;
        end
      end
      if (prev_hs && !bus.hsync) begin
        if (hs_run != 32) hs_len_bad++;
        hs_run = 0;
      end
      if (bus.vsync) begin
        vs_total++;
        if (vs_first < 0) vs_first = i;
        vs_last = i;
      end
      if (bus.frame_start) begin
        if (fs_prev >= 0) period = i - fs_prev;
        fs_prev = i;
      end
      prev_de = bus.de;
      prev_hs = bus.hsync;
    end
    check("de_lines",        32'(lines), 32'd144);
    check("de_run_bad",      32'(bad_runs), 32'd0);
    check("hsync_count",     32'(hs_count), 32'd163);
    check("hsync_len_bad",   32'(hs_len_bad), 32'd0);
    check("hsync_gaps",      32'(hs_gaps), 32'd144);
    check("hsync_gap_bad",   32'(hs_gap_bad), 32'd0);
    check("vsync_total",     32'(vs_total), 32'd1024);
    check("vsync_span",      32'(vs_last - vs_first + 1), 32'd1024);
    check("frame_period",    32'(period), 32'(FRAME));

    // Frame B: scroll 250/200 latched at its origin
    wait_pos(11);
    check("addr_h10_v0", 32'(bus.fb_addr), 32'h0000C804);
    wait_pos(50 * HT);
    scx = 8'd5;
    scy = 8'd0;
    wait_pos(60 * HT + 1);
    check("addr_h0_v60", 32'(bus.fb_addr), 32'h000004FA);

    // en dropped at (h=80, v=70)
    wait_pos(70 * HT + 80);
    en = 1'b0;
    step();
    check("en_drop_outputs", outs_vec(), 32'd0);
    step();
    step();
    en = 1'b1;
    step();
    check("restart_addr", 32'(bus.fb_addr), 32'h00000005);
    step();
    check("restart_de_early", 32'(bus.de), 32'd0);
    step();
    check("restart_de_fs_pix", outs_vec(), {19'd0, 8'd5, 1'b1, 1'b0, 1'b0, 1'b1});

    // Reset pulsed mid-line
    wait_pos(2 * HT + 100);
    scx   = 8'd0;
    scy   = 8'd0;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs_vec(), 32'd0);
    check("async_reset_addr", 32'(bus.fb_addr), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_restart_addr", 32'(bus.fb_addr), 32'd0);
    step();
    check("rst_restart_de_early", 32'(bus.de), 32'd0);
    step();
    check("rst_restart_de_fs_pix", outs_vec(), {19'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1});

    // Randomized en and scroll, checked by the scoreboard
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom_range(0, 39) != 0);
      scx = 8'($urandom);
      scy = 8'($urandom);
      step();
    end
    en = 1'b1;
    repeat (600) step();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter B, default 8, bits per pixel; equals the framebuffer pixel width.
REQ-002 SHALL have parameters H_ACT=160, H_FP=16, H_SYNC=32, H_BP=48: horizontal active, front porch, sync and back porch, in clocks.
REQ-003 SHALL have parameters V_ACT=144, V_FP=3, V_SYNC=4, V_BP=12: vertical active, front porch, sync and back porch, in lines.
REQ-004 clk  input  1  single clock for all logic; it also drives the framebuffer read-port clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  scanout enable.
REQ-007 scx  input  8  horizontal scroll offset into the 256x256 framebuffer.
REQ-008 scy  input  8  vertical scroll offset.
REQ-009 fb_addr  output  16  framebuffer read address, registered.
REQ-010 fb_data  input  B  framebuffer read data, valid one clk after fb_addr.
REQ-011 pix  output  B  pixel value; 0 when de=0.
REQ-012 de  output  1  data enable: active area.
REQ-013 hsync  output  1  horizontal sync, active-high.
REQ-014 vsync  output  1  vertical sync, active-high.
REQ-015 frame_start  output  1  one-clk pulse marking the first active pixel of each frame on pix.

Function
REQ-016 Counters SHALL be h in 0..HT-1 with HT=H_ACT+H_FP+H_SYNC+H_BP (256), and v in 0..VT-1 with VT=V_ACT+V_FP+V_SYNC+V_BP (163).
REQ-017 While en=1, h SHALL increment each clk; at HT-1 h wraps to 0 and v increments; at (HT-1,VT-1) both wrap to 0.
REQ-018 Stage-0 active SHALL be h<H_ACT and v<V_ACT.
REQ-019 Stage-0 hsync SHALL be H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC.
REQ-020 Stage-0 vsync SHALL be V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC, for whole lines.
REQ-021 scx and scy SHALL be latched into internal sx and sy only when the counters are at (0,0) with en=1; changes mid-frame SHALL have no effect until the next frame.
REQ-022 fb_addr SHALL be registered as {(v+sy) mod 256, (h+sx) mod 256}, 8-bit wrap on each byte, no carry between bytes.
REQ-023 During blanking fb_addr SHALL still update; its contents are don't-care.
REQ-024 Latency: the counter state at cycle t produces fb_addr at t+1, fb_data at t+2, and pix/de/hsync/vsync at t+3.
REQ-025 The control signals SHALL be delay-matched so all four outputs correspond to the same (h,v).
REQ-026 pix SHALL be registered as fb_data when the delayed active is 1, else 0.
REQ-027 frame_start SHALL be 1 exactly in the cycle where de first rises for (h=0,v=0); otherwise 0.
REQ-028 en=0 SHALL synchronously clear h, v and all pipeline valid/sync stages; pix, de, hsync, vsync and frame_start SHALL be 0 from the next edge.
REQ-029 After en rises, the first counter state SHALL be (0,0), so the first de appears 3 clks later, with frame_start.
REQ-030 A toggle of en mid-frame SHALL restart the frame at (0,0), with no partial-line output.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear h, v, sx, sy, fb_addr and all pipeline registers; outputs then read pix=0, de=0, hsync=0, vsync=0, frame_start=0, fb_addr=0.
REQ-032 After rst_n deasserts, behaviour SHALL be identical to en rising from 0.
REQ-033 Reset mid-frame SHALL discard in-flight pixels.

Structure
REQ-034 Timing defaults and the derived HT/VT SHALL live in shared package fb_pkg, reused by the framebuffer writer.
REQ-035 One sub-module is natural: fb_timing (h/v counters plus stage-0 active/hsync/vsync); addressing and pipeline stay in fb_scanout.

Verification
REQ-036 rst_n released, en=1, scx=scy=0, model returns fb_data=addr[7:0] -> first de at clk 3 with frame_start=1 and pix=0x00; pix increments 0..159 across the line.
REQ-037 scx=250, scy=200 at frame start -> fb_addr for (h=10,v=0) = 0xC804, and for (h=0,v=60) = 0x04FA.
REQ-038 Timing -> de high 160 clks per line; hsync high 32 clks starting 16 clks after de falls; vsync high 4x256 clks; frame period 41728 clks.
REQ-039 scx changed from 0 to 5 at v=50 -> no fb_addr change until the next frame; the next frame's first address is 0x0005.
REQ-040 en dropped at (h=80,v=70) -> all outputs 0 next clk; en reasserted -> de after 3 clks with frame_start.
REQ-041 rst_n pulsed low mid-line -> outputs 0 asynchronously; restart timing identical to REQ-036.
